// File: rtl/iadder_pkg.sv
// Shared definitions for the speculative-adder error recovery block:
// FSM states, widths and the segment boundaries of the approximate sum.
package iadder_pkg;

  localparam int unsigned OP_W   = 16;
  localparam int unsigned SUM_W  = 17;
  localparam int unsigned SEG_W  = 3;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned STAT_W = 16;
  localparam int unsigned LO_W   = 6;

  localparam int unsigned SEG0_LSB = 6;
  localparam int unsigned SEG1_LSB = 9;
  localparam int unsigned SEG2_LSB = 12;
  localparam int unsigned SEG3_LSB = 15;
  localparam int unsigned SEG0_MSB = 8;
  localparam int unsigned SEG1_MSB = 11;
  localparam int unsigned SEG2_MSB = 14;
  localparam int unsigned SEG3_MSB = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Bit position of the lowest bit of a segment
  function automatic int unsigned seg_lsb(input logic [1:0] idx);
    case (idx)
      2'd0:    return SEG0_LSB;
      2'd1:    return SEG1_LSB;
      2'd2:    return SEG2_LSB;
      default: return SEG3_LSB;
    endcase
  endfunction

  // Mask covering bits [msb:lsb] of a sum-width word
  function automatic logic [SUM_W-1:0] seg_mask_of(input int unsigned lsb, input int unsigned msb);
    return SUM_W'(((32'd1 << (msb - lsb + 1)) - 32'd1) << lsb);
  endfunction

endpackage

// File: rtl/iadder_err_recover_if.sv
// Operand/approximate-sum request channel, corrected-result channel and statistics.
interface iadder_err_recover_if import iadder_pkg::*; ();

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   A;
  logic [OP_W-1:0]   B;
  logic [SUM_W-1:0]  SUM_APX;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  SUM;
  logic [CNT_W-1:0]  err_cnt;
  logic              err_flag;
  logic [STAT_W-1:0] stat_ops;
  logic [STAT_W-1:0] stat_err;

  modport master (
    output in_valid, A, B, SUM_APX, out_ready,
    input  in_ready, out_valid, SUM, err_cnt, err_flag, stat_ops, stat_err
  );

  modport slave (
    input  in_valid, A, B, SUM_APX, out_ready,
    output in_ready, out_valid, SUM, err_cnt, err_flag, stat_ops, stat_err
  );

endinterface

// File: rtl/iadder_seg_check.sv
// Selects one segment of the approximate and exact sums by index and
// reports whether they differ, with the exact bits and the segment mask.
module iadder_seg_check import iadder_pkg::*; (
  input  logic [1:0]       seg_idx,
  input  logic [SUM_W-1:0] apx,
  input  logic [SUM_W-1:0] exact,
  output logic             mismatch,
  output logic [SEG_W-1:0] seg_bits,
  output logic [SUM_W-1:0] seg_mask
);

  logic [SEG_W-1:0] apx_bits;

  // Segment select; the top segment is two bits wide and zero-extended
  always_comb begin
    apx_bits = '0;
    seg_bits = '0;
    seg_mask = '0;
    case (seg_idx)
      2'd0: begin
        apx_bits = apx[SEG0_MSB:SEG0_LSB];
        seg_bits = exact[SEG0_MSB:SEG0_LSB];
        seg_mask = seg_mask_of(SEG0_LSB, SEG0_MSB);
      end
      2'd1: begin
        apx_bits = apx[SEG1_MSB:SEG1_LSB];
        seg_bits = exact[SEG1_MSB:SEG1_LSB];
        seg_mask = seg_mask_of(SEG1_LSB, SEG1_MSB);
      end
      2'd2: begin
        apx_bits = apx[SEG2_MSB:SEG2_LSB];
        seg_bits = exact[SEG2_MSB:SEG2_LSB];
        seg_mask = seg_mask_of(SEG2_LSB, SEG2_MSB);
      end
      default: begin
        apx_bits = SEG_W'(apx[SEG3_MSB:SEG3_LSB]);
        seg_bits = SEG_W'(exact[SEG3_MSB:SEG3_LSB]);
        seg_mask = seg_mask_of(SEG3_LSB, SEG3_MSB);
      end
    endcase
  end

  assign mismatch = (apx_bits != seg_bits);

endmodule

// File: rtl/iadder_err_recover.sv
// Error recovery for a segmented speculative adder: scans the upstream
// approximate sum one segment per cycle, repairs wrong segments from the
// exact sum and counts them. Fixed latency, one result per 6 cycles.
// Optional result statistics counters: define IADDER_ERR_STATS_EN.
module iadder_err_recover import iadder_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  iadder_err_recover_if.slave  bus
);

  state_e           state;
  logic [1:0]       seg_idx;
  logic [OP_W-1:0]  a_q;
  logic [OP_W-1:0]  b_q;
  logic [SUM_W-1:0] apx_q;
  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [SUM_W-1:0] exact;
  logic [LO_W-1:0]  acc_lo;
  logic             seg_mismatch;
  logic [SEG_W-1:0] seg_bits;
  logic [SUM_W-1:0] seg_mask;

  assign exact  = SUM_W'(a_q) + SUM_W'(b_q);
  assign acc_lo = bus.A[LO_W-1:0] + bus.B[LO_W-1:0];

  iadder_seg_check u_seg_check (
    .seg_idx  (seg_idx),
    .apx      (apx_q),
    .exact    (exact),
    .mismatch (seg_mismatch),
    .seg_bits (seg_bits),
    .seg_mask (seg_mask)
  );

  // Accept / scan / present FSM with registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      seg_idx     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      apx_q       <= '0;
      sum_q       <= '0;
      err_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.A;
            b_q        <= bus.B;
            apx_q      <= bus.SUM_APX;
            sum_q      <= {bus.SUM_APX[SUM_W-1:LO_W], acc_lo};
            err_cnt_q  <= '0;
            seg_idx    <= '0;
            in_ready_q <= 1'b0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (seg_mismatch) begin
            sum_q     <= (sum_q & ~seg_mask) | (SUM_W'(seg_bits) << seg_lsb(seg_idx));
            err_cnt_q <= err_cnt_q + CNT_W'(1);
          end
          if (seg_idx == 2'd3) begin
            out_valid_q <= 1'b1;
            state       <= OUT;
          end else begin
            seg_idx <= seg_idx + 2'd1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.SUM       = sum_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.err_flag  = (err_cnt_q != '0);

`ifdef IADDER_ERR_STATS_EN
  logic [STAT_W-1:0] stat_ops_q;
  logic [STAT_W-1:0] stat_err_q;
  logic              out_fire;

  assign out_fire = out_valid_q & bus.out_ready;

  // Saturating counts of delivered results and of corrected results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops_q <= '0;
      stat_err_q <= '0;
    end else if (out_fire) begin
      if (stat_ops_q != '1) begin
        stat_ops_q <= stat_ops_q + STAT_W'(1);
      end
      if (bus.err_flag && (stat_err_q != '1)) begin
        stat_err_q <= stat_err_q + STAT_W'(1);
      end
    end
  end

  assign bus.stat_ops = stat_ops_q;
  assign bus.stat_err = stat_err_q;
`else
  assign bus.stat_ops = '0;
  assign bus.stat_err = '0;
`endif

endmodule

// File: tb/tb_iadder_err_recover.sv
// Self-checking bench for iadder_err_recover: directed corner cases plus
// randomized bundles compared against an arithmetic reference model.
module tb_iadder_err_recover;
  import iadder_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  iadder_err_recover_if bus_if ();

  iadder_err_recover dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_err    = 0;
  int unsigned exp_ops = 0;
  int unsigned exp_err = 0;

  localparam int SLSB [4] = '{6, 9, 12, 15};
  localparam int SMSB [4] = '{8, 11, 14, 16};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Number of segments in which the approximate sum disagrees with the exact sum
  function automatic int model_err_cnt(input logic [16:0] exact, input logic [16:0] apx);
    int n;
    logic [16:0] diff;
    n = 0;
    diff = exact ^ apx;
    for (int s = 0; s < 4; s++) begin
      int unsigned w;
      logic [16:0] part;
      w = 32'(SMSB[s] - SLSB[s] + 1);
      part = (diff >> SLSB[s]) & 17'((32'd1 << w) - 32'd1);
      if (part != 17'd0) n++;
    end
    return n;
  endfunction

  function automatic logic [31:0] exp_stat(input int unsigned m);
`ifdef IADDER_ERR_STATS_EN
    return m;
`else
    return 32'(m) & 32'd0;
`endif
  endfunction

  task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                         input logic [16:0] apx, input int hold, input string tag);
    logic [16:0] exp_sum;
    int exp_cnt;
    int waited;
    int lat;
    exp_sum = {1'b0, a} + {1'b0, b};
    exp_cnt = model_err_cnt(exp_sum, apx);
    bus_if.A        = a;
    bus_if.B        = b;
    bus_if.SUM_APX  = apx;
    bus_if.in_valid = 1'b1;
    waited = 0;
    while (!bus_if.in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk({tag, "/in_ready"}, 32'(bus_if.in_ready), 32'd1);
    if (!bus_if.in_ready) begin
      bus_if.in_valid = 1'b0;
      return;
    end
    // accept edge
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    bus_if.A        = 16'($urandom);
    bus_if.B        = 16'($urandom);
    bus_if.SUM_APX  = 17'($urandom);
    // lat counts edges including the accept edge
    lat = 1;
    while (!bus_if.out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'd5);
    for (int h = 0; h < hold; h++) begin
      chk({tag, "/hold_valid"}, 32'(bus_if.out_valid), 32'd1);
      chk({tag, "/hold_sum"}, 32'(bus_if.SUM), 32'(exp_sum));
      chk({tag, "/hold_cnt"}, 32'(bus_if.err_cnt), 32'(exp_cnt));
      chk({tag, "/hold_in_ready"}, 32'(bus_if.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, "/sum"}, 32'(bus_if.SUM), 32'(exp_sum));
    chk({tag, "/err_cnt"}, 32'(bus_if.err_cnt), 32'(exp_cnt));
    chk({tag, "/err_flag"}, 32'(bus_if.err_flag), 32'(exp_cnt != 0));
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    if (exp_ops != 32'hFFFF) exp_ops++;
    if (exp_cnt != 0 && exp_err != 32'hFFFF) exp_err++;
    chk({tag, "/done_valid"}, 32'(bus_if.out_valid), 32'd0);
    chk({tag, "/done_in_ready"}, 32'(bus_if.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    logic [16:0] rapx, rex;
    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.A         = '0;
    bus_if.B         = '0;
    bus_if.SUM_APX   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rst/sum", 32'(bus_if.SUM), 32'd0);
    chk("rst/err_cnt", 32'(bus_if.err_cnt), 32'd0);
    chk("rst/stat_ops", 32'(bus_if.stat_ops), 32'd0);
    chk("rst/stat_err", 32'(bus_if.stat_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst/in_ready", 32'(bus_if.in_ready), 32'd1);

    // reset during the third scan cycle discards the in-flight result
    bus_if.A        = 16'hFFFF;
    bus_if.B        = 16'hFFFF;
    bus_if.SUM_APX  = 17'h00000;
    bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_ops = 0;
    exp_err = 0;
    #1;
    chk("abort/out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("abort/sum", 32'(bus_if.SUM), 32'd0);
    chk("abort/stat_ops", 32'(bus_if.stat_ops), exp_stat(exp_ops));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort/in_ready", 32'(bus_if.in_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("abort/no_output", 32'(bus_if.out_valid), 32'd0);

    run_txn(16'h003F, 16'h0001, 17'h00000, 0, "carry_seg0");
    run_txn(16'h1234, 16'h1111, 17'h02345, 0, "clean");
    run_txn(16'hFFFF, 16'h0001, 17'h00000, 0, "carry_out");
    chk("stats3/ops", 32'(bus_if.stat_ops), exp_stat(32'd3));
    chk("stats3/err", 32'(bus_if.stat_err), exp_stat(32'd2));
    run_txn(16'hFFFF, 16'hFFFF, 17'h0003E, 3, "all_seg_hold");

    for (int i = 0; i < 40; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rex = {1'b0, ra} + {1'b0, rb};
      case ($urandom_range(0, 2))
        0:       rapx = rex;
        1:       rapx = 17'($urandom);
        default: rapx = rex ^ (17'($urandom) & 17'h1FFC0);
      endcase
      rapx[5:0] = 6'($urandom);
      run_txn(ra, rb, rapx, int'($urandom_range(0, 3)), "rand");
    end

    chk("final/stat_ops", 32'(bus_if.stat_ops), exp_stat(exp_ops));
    chk("final/stat_err", 32'(bus_if.stat_err), exp_stat(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
